// File: rtl/seq_div16_if.sv
// Handshake and result bundle for the 16-bit sequential divider.
// The master drives requests; the slave (divider) returns status and results.
interface seq_div16_if;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] q;
    logic [15:0] r;
    logic        divzero;

    modport master (output start, a, b, input busy, done, q, r, divzero);
    modport slave  (input start, a, b, output busy, done, q, r, divzero);
endinterface

// File: rtl/seq_div16.sv
// 16-bit unsigned restoring divider: one quotient bit per clock, MSB first,
// 16-cycle latency, single-cycle done pulse and divide-by-zero shortcut.
module seq_div16 (
    input  logic        clk,
    input  logic        rst,
    seq_div16_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state, state_nxt;
    logic [15:0] dvd;      // dividend shifts out MSB first, quotient bits shift in
    logic [15:0] dvs;
    logic [16:0] rem;
    logic [3:0]  cnt;
    logic [15:0] q_reg, r_reg;
    logic        dz_reg;

    logic        accept;
    logic        last;
    logic [17:0] shifted;
    logic [17:0] trial;
    logic        qbit;
    logic [16:0] rem_nxt;

    assign accept = bus.start && (state != RUN);
    assign last   = (cnt == 4'd15);

    // Widened by one bit so the subtraction borrow lands in trial[17].
    assign shifted = {rem, dvd[15]};
    assign trial   = shifted - {2'b00, dvs};
    assign qbit    = ~trial[17];
    assign rem_nxt = qbit ? trial[16:0] : shifted[16:0];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: default assignment first so no path leaves state_nxt unassigned
    // (which would infer a latch).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (dvs == 16'd0 || last) state_nxt = DONE;
            DONE:    state_nxt = bus.start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy    = (state == RUN);
        bus.done    = (state == DONE);
        bus.q       = q_reg;
        bus.r       = r_reg;
        bus.divzero = dz_reg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dvd    <= '0;
            dvs    <= '0;
            rem    <= '0;
            cnt    <= '0;
            q_reg  <= '0;
            r_reg  <= '0;
            dz_reg <= 1'b0;
        end else if (accept) begin
            dvd    <= bus.a;
            dvs    <= bus.b;
            rem    <= '0;
            cnt    <= '0;
            dz_reg <= 1'b0;
        end else if (state == RUN) begin
            if (dvs == 16'd0) begin
                q_reg  <= 16'hFFFF;
                r_reg  <= dvd;
                dz_reg <= 1'b1;
            end else begin
                dvd <= {dvd[14:0], qbit};
                rem <= rem_nxt;
                cnt <= cnt + 4'd1;
                if (last) begin
                    q_reg <= {dvd[14:0], qbit};
                    r_reg <= rem_nxt[15:0];
                end
            end
        end
    end
endmodule

// File: tb/tb_seq_div16.sv
// Directed and back-to-back regression bench for seq_div16; inputs change and
// outputs are sampled on the falling edge.
module tb_seq_div16;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    seq_div16_if bus ();
    seq_div16 dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Caller must be at a falling edge; returns at the falling edge where done
    // is seen (or after a bounded wait). lat counts edges from accept to done.
    task automatic do_op(input logic [15:0] av, input logic [15:0] bv,
                         output int lat, output int busy_cnt,
                         output logic dz_acc, output logic [15:0] q_acc);
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        @(posedge clk);
        lat = 0; busy_cnt = 0; dz_acc = 1'bx; q_acc = 'x;
        while (lat < 40) begin
            @(negedge clk);
            if (lat == 0) begin
                bus.start = 1'b0;
                dz_acc    = bus.divzero;
                q_acc     = bus.q;
                bus.a     = ~av;
                bus.b     = ~bv;
            end
            if (bus.done) break;
            if (bus.busy) busy_cnt++;
            @(posedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; bus.start = 1'b0; bus.a = 16'h0; bus.b = 16'h0;
        repeat (2) @(negedge clk);
        n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        n_checks++; if (bus.done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        n_checks++; if ({bus.q, bus.r} !== 32'h0) begin n_errors++; $display("FAIL reset_qr: got %h expected 0", {bus.q, bus.r}); end
        n_checks++; if (bus.divzero !== 1'b0) begin n_errors++; $display("FAIL reset_dz: got %b expected 0", bus.divzero); end
        // start held while reset releases: only the edge with rst low accepts
        bus.start = 1'b1; bus.a = 16'd9; bus.b = 16'd2;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL reset_release_busy: got %b expected 0", bus.busy); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic;
        int lat, bc; logic dz; logic [15:0] q0;
        do_op(16'd100, 16'd7, lat, bc, dz, q0);
        n_checks++; if (lat !== 16) begin n_errors++; $display("FAIL basic_latency: got %0d expected 16", lat); end
        n_checks++; if (bc !== 16) begin n_errors++; $display("FAIL basic_busy_cycles: got %0d expected 16", bc); end
        n_checks++; if (bus.q !== 16'd14) begin n_errors++; $display("FAIL basic_q: got %0d expected 14", bus.q); end
        n_checks++; if (bus.r !== 16'd2) begin n_errors++; $display("FAIL basic_r: got %0d expected 2", bus.r); end
        n_checks++; if (bus.divzero !== 1'b0) begin n_errors++; $display("FAIL basic_dz: got %b expected 0", bus.divzero); end
        @(negedge clk);
        n_checks++; if (bus.done !== 1'b0) begin n_errors++; $display("FAIL basic_done_width: got %b expected 0", bus.done); end
        n_checks++; if (bus.q !== 16'd14) begin n_errors++; $display("FAIL basic_q_hold: got %0d expected 14", bus.q); end
    endtask

    task automatic test_extreme;
        int lat, bc; logic dz; logic [15:0] q0;
        do_op(16'hFFFF, 16'h0001, lat, bc, dz, q0);
        n_checks++; if ({bus.q, bus.r} !== {16'hFFFF, 16'h0000}) begin n_errors++; $display("FAIL ext_ffff_1: got %h expected ffff0000", {bus.q, bus.r}); end
        @(negedge clk);
        do_op(16'hFFFF, 16'h8000, lat, bc, dz, q0);
        n_checks++; if ({bus.q, bus.r} !== {16'h0001, 16'h7FFF}) begin n_errors++; $display("FAIL ext_ffff_8000: got %h expected 00017fff", {bus.q, bus.r}); end
        n_checks++; if (lat !== 16) begin n_errors++; $display("FAIL ext_latency: got %0d expected 16", lat); end
        @(negedge clk);
        do_op(16'd7, 16'd100, lat, bc, dz, q0);
        n_checks++; if ({bus.q, bus.r} !== {16'd0, 16'd7}) begin n_errors++; $display("FAIL ext_small_dividend: got %h expected 00000007", {bus.q, bus.r}); end
        @(negedge clk);
    endtask

    task automatic test_divzero;
        int lat, bc; logic dz; logic [15:0] q0;
        do_op(16'h1234, 16'h0000, lat, bc, dz, q0);
        n_checks++; if (lat !== 1) begin n_errors++; $display("FAIL dz_latency: got %0d expected 1", lat); end
        n_checks++; if ({bus.q, bus.r} !== {16'hFFFF, 16'h1234}) begin n_errors++; $display("FAIL dz_qr: got %h expected ffff1234", {bus.q, bus.r}); end
        n_checks++; if (bus.divzero !== 1'b1) begin n_errors++; $display("FAIL dz_flag: got %b expected 1", bus.divzero); end
        // back-to-back start on the done cycle
        do_op(16'd3, 16'd9, lat, bc, dz, q0);
        n_checks++; if (dz !== 1'b0) begin n_errors++; $display("FAIL b2b_dz_clear: got %b expected 0", dz); end
        n_checks++; if (q0 !== 16'hFFFF) begin n_errors++; $display("FAIL b2b_q_hold: got %h expected ffff", q0); end
        n_checks++; if (lat !== 16) begin n_errors++; $display("FAIL b2b_latency: got %0d expected 16", lat); end
        n_checks++; if ({bus.q, bus.r} !== {16'd0, 16'd3}) begin n_errors++; $display("FAIL b2b_qr: got %h expected 00000003", {bus.q, bus.r}); end
        @(negedge clk);
    endtask

    task automatic test_start_during_busy;
        int dones = 0;
        bus.start = 1'b1; bus.a = 16'd100; bus.b = 16'd7;
        @(posedge clk);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (i == 0) bus.start = 1'b0;
            if (i == 5) begin bus.start = 1'b1; bus.a = 16'd50; bus.b = 16'd5; end
            if (i == 6) bus.start = 1'b0;
            if (bus.done) dones++;
        end
        n_checks++; if (dones !== 1) begin n_errors++; $display("FAIL overlap_done_count: got %0d expected 1", dones); end
        n_checks++; if ({bus.q, bus.r} !== {16'd14, 16'd2}) begin n_errors++; $display("FAIL overlap_qr: got %h expected 000e0002", {bus.q, bus.r}); end
    endtask

    task automatic test_reset_mid;
        int lat, bc, dones = 0; logic dz; logic [15:0] q0;
        bus.start = 1'b1; bus.a = 16'd100; bus.b = 16'd7;
        @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) bus.start = 1'b0;
        end
        rst = 1'b1;
        #1;
        n_checks++; if ({bus.busy, bus.done, bus.divzero} !== 3'b000) begin n_errors++; $display("FAIL midrst_flags: got %b expected 000", {bus.busy, bus.done, bus.divzero}); end
        n_checks++; if ({bus.q, bus.r} !== 32'h0) begin n_errors++; $display("FAIL midrst_qr: got %h expected 0", {bus.q, bus.r}); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        n_checks++; if (dones !== 0) begin n_errors++; $display("FAIL midrst_no_done: got %0d expected 0", dones); end
        do_op(16'd100, 16'd7, lat, bc, dz, q0);
        n_checks++; if (lat !== 16) begin n_errors++; $display("FAIL midrst_latency: got %0d expected 16", lat); end
        n_checks++; if ({bus.q, bus.r} !== {16'd14, 16'd2}) begin n_errors++; $display("FAIL midrst_qr: got %h expected 000e0002", {bus.q, bus.r}); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back_random;
        int lat, bc; logic dz; logic [15:0] q0;
        logic [15:0] av, bv, eq, er; logic edz;
        for (int n = 0; n < 2000; n++) begin
            av = 16'($urandom);
            bv = ($urandom_range(0, 15) == 0) ? 16'd0 : 16'($urandom >> $urandom_range(0, 16));
            if (bv == 16'd0) begin eq = 16'hFFFF; er = av; edz = 1'b1; end
            else begin eq = av / bv; er = av % bv; edz = 1'b0; end
            do_op(av, bv, lat, bc, dz, q0);
            n_checks++; if ({bus.q, bus.r, bus.divzero} !== {eq, er, edz}) begin n_errors++; $display("FAIL rand_%0d %h/%h: got q=%h r=%h dz=%b expected q=%h r=%h dz=%b", n, av, bv, bus.q, bus.r, bus.divzero, eq, er, edz); end
            n_checks++; if (lat !== (edz ? 1 : 16)) begin n_errors++; $display("FAIL rand_latency_%0d: got %0d expected %0d", n, lat, edz ? 1 : 16); end
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extreme();
        test_divzero();
        test_start_during_busy();
        test_reset_mid();
        test_back_to_back_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
